// File: rtl/lcd_msg_seq.sv
// HD44780 16x2 sequencer: power-up delay, init commands, then full-screen frames
// fetched from an external message ROM, with coherent per-frame message latching.
module lcd_msg_seq #(
  parameter int SEL_W        = 4,
  parameter int EN_PULSE     = 16,
  parameter int CMD_GAP      = 262143,
  parameter int PWR_DLY      = 1000000,
  parameter int AUTO_REFRESH = 0
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [SEL_W-1:0] iSEL,
  input  logic             iREFRESH,
  output logic [SEL_W-1:0] oMSG,
  output logic [4:0]       oCHAR_ADDR,
  input  logic [7:0]       iCHAR,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RW,
  output logic             LCD_EN,
  output logic             LCD_RS,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);
  localparam int MAXC = (PWR_DLY > CMD_GAP) ? ((PWR_DLY > EN_PULSE) ? PWR_DLY : EN_PULSE)
                                            : ((CMD_GAP > EN_PULSE) ? CMD_GAP : EN_PULSE);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [5:0] LAST = 6'd37;

  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, GAP, FRAME_END, IDLE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [5:0]       idx, idx_nx;
  logic [SEL_W-1:0] msg_nx;
  logic             pend, pend_nx, init_done, init_nx;
  logic [7:0]       data_nx;
  logic             rs_nx, en_nx, done_nx;
  logic             is_char, evt, last;
  logic [7:0]       cmd;

  assign is_char = ((idx >= 6'd5) && (idx <= 6'd20)) || (idx >= 6'd22);
  assign evt     = iREFRESH || (iSEL != oMSG);
  assign last    = (idx == LAST);
  assign oBUSY   = (state != IDLE);
  assign LCD_RW  = 1'b0;

  always_comb begin
    cmd = 8'h00;
    case (idx)
      6'd0:    cmd = 8'h38;
      6'd1:    cmd = 8'h0C;
      6'd2:    cmd = 8'h01;
      6'd3:    cmd = 8'h06;
      6'd4:    cmd = 8'h80;
      6'd21:   cmd = 8'hC0;
      default: cmd = 8'h00;
    endcase
  end

  // Column arithmetic is mod 16, so only idx[3:0] matters (22 mod 16 = 6).
  always_comb begin
    oCHAR_ADDR = 5'd0;
    if ((idx >= 6'd5) && (idx <= 6'd20)) oCHAR_ADDR = {1'b0, idx[3:0] - 4'd5};
    else if (idx >= 6'd22)               oCHAR_ADDR = {1'b1, idx[3:0] - 4'd6};
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    msg_nx   = oMSG;
    pend_nx  = pend;
    init_nx  = init_done;
    data_nx  = LCD_DATA;
    rs_nx    = LCD_RS;
    en_nx    = 1'b0;
    done_nx  = 1'b0;
    if ((state == SETUP || state == PULSE || state == HOLD || state == GAP) && evt)
      pend_nx = 1'b1;
    case (state)
      PWRUP: begin
        if (cnt == CW'(PWR_DLY - 1)) begin
          msg_nx   = iSEL;
          idx_nx   = 6'd0;
          cnt_nx   = '0;
          state_nx = SETUP;
        end else cnt_nx = cnt + CW'(1);
      end
      SETUP: begin
        data_nx  = is_char ? iCHAR : cmd;
        rs_nx    = is_char;
        en_nx    = 1'b1;
        cnt_nx   = '0;
        state_nx = PULSE;
      end
      PULSE: begin
        if (cnt == CW'(EN_PULSE - 1)) begin
          cnt_nx   = '0;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
          en_nx  = 1'b1;
        end
      end
      HOLD: begin
        cnt_nx = '0;
        if (last && CMD_GAP == 1) begin
          done_nx  = 1'b1;
          init_nx  = 1'b1;
          state_nx = FRAME_END;
        end else state_nx = GAP;
      end
      // FRAME_END stands in for the final gap cycle of write 37, keeping frames
      // at exactly 34 write slots when redrawn back-to-back.
      GAP: begin
        if (last && cnt == CW'(CMD_GAP - 2)) begin
          cnt_nx   = '0;
          done_nx  = 1'b1;
          init_nx  = 1'b1;
          state_nx = FRAME_END;
        end else if (!last && cnt == CW'(CMD_GAP - 1)) begin
          cnt_nx   = '0;
          idx_nx   = idx + 6'd1;
          state_nx = SETUP;
        end else cnt_nx = cnt + CW'(1);
      end
      FRAME_END: begin
        pend_nx = 1'b0;
        if (pend || (AUTO_REFRESH != 0) || evt) begin
          msg_nx   = iSEL;
          idx_nx   = init_done ? 6'd4 : 6'd0;
          cnt_nx   = '0;
          state_nx = SETUP;
        end else state_nx = IDLE;
      end
      IDLE: begin
        if (evt) begin
          msg_nx   = iSEL;
          idx_nx   = init_done ? 6'd4 : 6'd0;
          cnt_nx   = '0;
          state_nx = SETUP;
        end
      end
      default: state_nx = PWRUP;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= PWRUP;
      cnt         <= '0;
      idx         <= '0;
      oMSG        <= '0;
      pend        <= 1'b0;
      init_done   <= 1'b0;
      LCD_DATA    <= 8'h00;
      LCD_RS      <= 1'b0;
      LCD_EN      <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      oMSG        <= msg_nx;
      pend        <= pend_nx;
      init_done   <= init_nx;
      LCD_DATA    <= data_nx;
      LCD_RS      <= rs_nx;
      LCD_EN      <= en_nx;
      oFRAME_DONE <= done_nx;
    end
  end
endmodule

// File: tb/tb_lcd_msg_seq.sv
// Scoreboard bench for lcd_msg_seq: expected LCD writes are queued by stimulus
// and checked by a monitor on every EN rising edge.
module tb_lcd_msg_seq;
  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [3:0] sel, sel2;
  logic       refresh;
  logic [3:0] msg, msg2;
  logic [4:0] addr, addr2;
  logic [7:0] ch, ch2, data, data2;
  logic       rw, en, rs, busy, done;
  logic       rw2, en2, rs2, busy2, done2;

  always #5 clk = ~clk;

  lcd_msg_seq #(.SEL_W(4), .EN_PULSE(2), .CMD_GAP(4), .PWR_DLY(10), .AUTO_REFRESH(0)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSEL(sel), .iREFRESH(refresh), .oMSG(msg),
    .oCHAR_ADDR(addr), .iCHAR(ch), .LCD_DATA(data), .LCD_RW(rw), .LCD_EN(en),
    .LCD_RS(rs), .oBUSY(busy), .oFRAME_DONE(done));

  lcd_msg_seq #(.SEL_W(4), .EN_PULSE(2), .CMD_GAP(4), .PWR_DLY(10), .AUTO_REFRESH(1)) dut2 (
    .iCLK(clk), .iRST_N(rst2_n), .iSEL(sel2), .iREFRESH(1'b0), .oMSG(msg2),
    .oCHAR_ADDR(addr2), .iCHAR(ch2), .LCD_DATA(data2), .LCD_RW(rw2), .LCD_EN(en2),
    .LCD_RS(rs2), .oBUSY(busy2), .oFRAME_DONE(done2));

  // Message ROM: 0x40+col on line 0, 0x60+col on line 1.
  assign ch  = addr[4]  ? (8'h60 + {4'h0, addr[3:0]})  : (8'h40 + {4'h0, addr[3:0]});
  assign ch2 = addr2[4] ? (8'h60 + {4'h0, addr2[3:0]}) : (8'h40 + {4'h0, addr2[3:0]});

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] msg;
    bit         gchk;
  } wr_t;

  wr_t q[$];
  int  tests = 0, fails = 0;
  bit  mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_one(input logic r, input logic [7:0] d, input logic [3:0] m, input bit g);
    wr_t e;
    e.rs = r; e.data = d; e.msg = m; e.gchk = g;
    q.push_back(e);
  endtask

  task automatic push_seq(input bit full, input logic [3:0] m);
    if (full) begin
      push_one(1'b0, 8'h38, m, 1'b0);
      push_one(1'b0, 8'h0C, m, 1'b1);
      push_one(1'b0, 8'h01, m, 1'b1);
      push_one(1'b0, 8'h06, m, 1'b1);
    end
    push_one(1'b0, 8'h80, m, full);
    for (int c = 0; c < 16; c++) push_one(1'b1, 8'h40 + 8'(c), m, 1'b1);
    push_one(1'b0, 8'hC0, m, 1'b1);
    for (int c = 0; c < 16; c++) push_one(1'b1, 8'h60 + 8'(c), m, 1'b1);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic idle_chk(input string nm);
    repeat (5) @(negedge clk);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_queue_left"}, 32'(q.size()), 32'd0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_en"}, 32'(en), 32'd0);
    chk({nm, "_rs"}, 32'(rs), 32'd0);
    chk({nm, "_data"}, 32'(data), 32'd0);
    chk({nm, "_rw"}, 32'(rw), 32'd0);
    chk({nm, "_msg"}, 32'(msg), 32'd0);
    chk({nm, "_addr"}, 32'(addr), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd0);
  endtask

  // Write monitor: content on EN rise, pulse width on EN fall, spacing between rises.
  int  cyc = 0, last_rise = 0, hi = 0;
  bit  prev_en = 0, in_pulse = 0, have_prev = 0;
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!mon_en) begin
      in_pulse  = 0;
      have_prev = 0;
    end else if (en && !prev_en) begin
      if (q.size() == 0) chk("extra_write", 32'(data), 32'hFFFF);
      else begin
        e = q.pop_front();
        chk("wr_rs", 32'(rs), 32'(e.rs));
        chk("wr_data", 32'(data), 32'(e.data));
        chk("wr_msg", 32'(msg), 32'(e.msg));
        if (e.gchk && have_prev) chk("wr_spacing", 32'(cyc - last_rise), 32'd8);
      end
      last_rise = cyc;
      have_prev = 1;
      in_pulse  = 1;
      hi        = 1;
    end else if (en && in_pulse) begin
      hi++;
    end else if (!en && prev_en && in_pulse) begin
      chk("en_width", 32'(hi), 32'd2);
      in_pulse = 0;
    end
    prev_en = en;
  end

  // Auto-refresh instance: fixed frame period and never idle once running.
  int c2 = 0, last2 = 0, nd2 = 0, idle2 = 0;
  always @(negedge clk) begin
    if (rst2_n) begin
      c2++;
      if (done2) begin
        if (nd2 > 0) chk("auto_period", 32'(c2 - last2), 32'd272);
        last2 = c2;
        nd2++;
      end
      if (nd2 > 0 && !busy2) idle2++;
    end
  end

  initial begin
    int n;
    rst_n = 0; rst2_n = 0; sel = 4'd1; sel2 = 4'd7; refresh = 0;
    repeat (3) @(posedge clk);
    #1 reset_vals("reset");

    @(negedge clk);
    push_seq(1'b1, 4'd1);
    mon_en = 1;
    rst_n  = 1;
    rst2_n = 1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (en) break;
    end
    chk("first_en_rise_cycle", 32'(n), 32'd11);
    wait_done("init_frame_done");
    idle_chk("init_idle");

    @(negedge clk);
    sel = 4'd5;
    push_seq(1'b0, 4'd5);
    @(posedge clk); #1;
    chk("sel_change_busy", 32'(busy), 32'd1);
    wait_done("sel5_frame_done");
    idle_chk("sel5_idle");

    // Redraw of 5 interrupted by select changes and a refresh: one extra frame of 3.
    @(negedge clk);
    push_seq(1'b0, 4'd5);
    push_seq(1'b0, 4'd3);
    refresh = 1;
    @(negedge clk) refresh = 0;
    repeat (50) @(negedge clk);
    sel = 4'd2;
    repeat (30) @(negedge clk);
    sel = 4'd3;
    repeat (20) @(negedge clk);
    refresh = 1;
    @(negedge clk) refresh = 0;
    wait_done("mid_frame5_done");
    wait_done("mid_frame3_done");
    idle_chk("mid_idle");

    // Reset while EN is high.
    @(negedge clk);
    mon_en  = 0;
    refresh = 1;
    @(negedge clk) refresh = 0;
    for (int i = 0; i < 100; i++) begin
      if (en) break;
      @(negedge clk);
    end
    chk("en_high_before_rst", 32'(en), 32'd1);
    rst_n = 0;
    @(posedge clk); #1 reset_vals("midrst");
    @(negedge clk);
    q.delete();
    push_seq(1'b1, 4'd3);
    mon_en = 1;
    rst_n  = 1;
    wait_done("restart_frame_done");
    idle_chk("restart_idle");

    chk("auto_frames_seen", 32'(nd2 >= 3), 32'd1);
    chk("auto_never_idle", 32'(idle2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
